// File: rtl/uart_rx.sv
// 8N1 UART receiver (LSB first, no parity) with a 2-FF input synchroniser,
// mid-bit sampling, false-start rejection, framing-error flag and break hold-off.
module uart_rx #(
  parameter int CLKS_PER_BIT = 1250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       frame_err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    CLEANUP = 3'd4,
    BREAK   = 3'd5
  } state_t;

  localparam logic [31:0] HALF = 32'((CLKS_PER_BIT - 1) / 2);
  localparam logic [31:0] LAST = 32'(CLKS_PER_BIT - 1);

  logic        rx_meta;
  logic        rx_s;
  state_t      state, state_next;
  logic [31:0] clk_count, clk_count_next;
  logic [2:0]  bit_index, bit_index_next;
  logic [7:0]  shift, shift_next;
  logic [7:0]  rx_data_next;
  logic        rx_valid_next;
  logic        frame_err_next;

  // Synchroniser resets to the idle level so a reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the clock edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      clk_count <= '0;
      bit_index <= '0;
      shift     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_next;
      clk_count <= clk_count_next;
      bit_index <= bit_index_next;
      shift     <= shift_next;
      rx_data   <= rx_data_next;
      rx_valid  <= rx_valid_next;
      frame_err <= frame_err_next;
    end
  end

  always_comb begin
    // NOTE: every output of this block is given a default first, so no path
    // through the case statement leaves a signal unassigned and infers a latch.
    state_next     = state;
    clk_count_next = clk_count;
    bit_index_next = bit_index;
    shift_next     = shift;
    rx_data_next   = rx_data;
    rx_valid_next  = 1'b0;
    frame_err_next = 1'b0;

    case (state)
      IDLE: begin
        clk_count_next = '0;
        bit_index_next = '0;
        if (!rx_s) state_next = START;
      end

      START: begin
        if (clk_count == HALF) begin
          clk_count_next = '0;
          state_next     = rx_s ? IDLE : DATA;
        end else begin
          clk_count_next = clk_count + 32'd1;
        end
      end

      DATA: begin
        if (clk_count == LAST) begin
          clk_count_next        = '0;
          shift_next[bit_index] = rx_s;
          if (bit_index == 3'd7) begin
            bit_index_next = '0;
            state_next     = STOP;
          end else begin
            bit_index_next = bit_index + 3'd1;
          end
        end else begin
          clk_count_next = clk_count + 32'd1;
        end
      end

      STOP: begin
        if (clk_count == LAST) begin
          clk_count_next = '0;
          if (rx_s) begin
            rx_data_next  = shift;
            rx_valid_next = 1'b1;
            state_next    = CLEANUP;
          end else begin
            frame_err_next = 1'b1;
            state_next     = BREAK;
          end
        end else begin
          clk_count_next = clk_count + 32'd1;
        end
      end

      CLEANUP: state_next = IDLE;

      // A line held low after a bad stop bit must not be re-read as a new start.
      BREAK: begin
        clk_count_next = '0;
        if (rx_s) state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: a fast instance (16 clk/bit) for functional cases
// and a slow instance (1250 clk/bit) for baud-rate tolerance.
module tb_uart_rx;

  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_fast = 1'b1;
  logic       rx_slow = 1'b1;
  logic [7:0] data_f, data_s;
  logic       valid_f, valid_s, busy_f, busy_s, err_f, err_s;

  int tests_run = 0;
  int tests_failed = 0;

  exp_t q_fast[$];
  exp_t q_slow[$];
  exp_t ef, es;
  logic prev_pulse_f = 1'b0;
  logic prev_pulse_s = 1'b0;

  always #5 clk = ~clk;

  uart_rx #(.CLKS_PER_BIT(16)) dut (
    .clk(clk), .rst(rst), .rx(rx_fast),
    .rx_data(data_f), .rx_valid(valid_f), .rx_busy(busy_f), .frame_err(err_f)
  );

  uart_rx #(.CLKS_PER_BIT(1250)) dut_slow (
    .clk(clk), .rst(rst), .rx(rx_slow),
    .rx_data(data_s), .rx_valid(valid_s), .rx_busy(busy_s), .frame_err(err_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard monitors: every pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (valid_f || err_f) begin
      check("f_exclusive", {31'b0, valid_f & err_f}, 32'd0);
      check("f_pulse_gap", {31'b0, prev_pulse_f}, 32'd0);
      if (q_fast.size() == 0) begin
        check("f_unexpected_pulse", {30'b0, valid_f, err_f}, 32'd0);
      end else begin
        ef = q_fast.pop_front();
        check("f_kind_err", {31'b0, err_f}, {31'b0, ef.err});
        if (valid_f) check("f_data", {24'b0, data_f}, {24'b0, ef.data});
      end
    end
    prev_pulse_f = valid_f | err_f;
  end

  always @(negedge clk) begin
    if (valid_s || err_s) begin
      check("s_exclusive", {31'b0, valid_s & err_s}, 32'd0);
      check("s_pulse_gap", {31'b0, prev_pulse_s}, 32'd0);
      if (q_slow.size() == 0) begin
        check("s_unexpected_pulse", {30'b0, valid_s, err_s}, 32'd0);
      end else begin
        es = q_slow.pop_front();
        check("s_kind_err", {31'b0, err_s}, {31'b0, es.err});
        if (valid_s) check("s_data", {24'b0, data_s}, {24'b0, es.data});
      end
    end
    prev_pulse_s = valid_s | err_s;
  end

  task automatic drive(input bit slow, input logic v, input int n);
    if (slow) rx_slow = v;
    else rx_fast = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input bit slow, input logic [7:0] d, input int bit_clks,
                            input logic stop, input bit chk_busy);
    drive(slow, 1'b0, bit_clks);
    for (int i = 0; i < 8; i++) begin
      drive(slow, d[i], bit_clks);
      if (chk_busy && i == 3) check("busy_mid_frame", {31'b0, slow ? busy_s : busy_f}, 32'd1);
    end
    drive(slow, stop, bit_clks);
  endtask

  task automatic push(input bit slow, input logic err, input logic [7:0] d);
    exp_t e;
    e.err  = err;
    e.data = d;
    if (slow) q_slow.push_back(e);
    else q_fast.push_back(e);
  endtask

  task automatic wait_drain(input bit slow, input int budget);
    for (int i = 0; i < budget; i++) begin
      if ((slow ? q_slow.size() : q_fast.size()) == 0) break;
      @(negedge clk);
    end
    check(slow ? "s_drain" : "f_drain", slow ? q_slow.size() : q_fast.size(), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_data", {24'b0, data_f}, 32'h00);
    check("reset_valid", {31'b0, valid_f}, 32'd0);
    check("reset_busy", {31'b0, busy_f}, 32'd0);
    check("reset_ferr", {31'b0, err_f}, 32'd0);
    repeat (4) @(negedge clk);

    // Single byte.
    push(1'b0, 1'b0, 8'hA5);
    send_frame(1'b0, 8'hA5, 16, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 16);
    wait_drain(1'b0, 200);
    check("busy_after_frame", {31'b0, busy_f}, 32'd0);
    check("data_held_a5", {24'b0, data_f}, 32'hA5);

    // Back-to-back frames with one stop bit each.
    push(1'b0, 1'b0, 8'h00);
    push(1'b0, 1'b0, 8'hFF);
    push(1'b0, 1'b0, 8'h55);
    send_frame(1'b0, 8'h00, 16, 1'b1, 1'b0);
    send_frame(1'b0, 8'hFF, 16, 1'b1, 1'b0);
    send_frame(1'b0, 8'h55, 16, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 32);
    wait_drain(1'b0, 200);

    // False start: 5-clk low glitch.
    drive(1'b0, 1'b0, 4);
    check("glitch_busy_start", {31'b0, busy_f}, 32'd1);
    drive(1'b0, 1'b0, 1);
    drive(1'b0, 1'b1, 7);
    check("glitch_busy_clk12", {31'b0, busy_f}, 32'd0);
    drive(1'b0, 1'b1, 32);

    // Framing error followed by a held-low break, then a good frame.
    push(1'b0, 1'b1, 8'h00);
    send_frame(1'b0, 8'h3C, 16, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 30);
    check("break_busy", {31'b0, busy_f}, 32'd1);
    check("break_data_kept", {24'b0, data_f}, 32'h55);
    drive(1'b0, 1'b0, 10);
    wait_drain(1'b0, 10);
    drive(1'b0, 1'b1, 32);
    check("break_released", {31'b0, busy_f}, 32'd0);
    push(1'b0, 1'b0, 8'h81);
    send_frame(1'b0, 8'h81, 16, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 16);
    wait_drain(1'b0, 200);

    // Reset in the middle of bit 4 of 8'hC3.
    drive(1'b0, 1'b0, 16);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1 & (8'hC3 >> i), 16);
    drive(1'b0, 1'b0, 8);
    rst = 1'b1;
    rx_fast = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_data", {24'b0, data_f}, 32'h00);
    check("midrst_valid", {31'b0, valid_f}, 32'd0);
    check("midrst_busy", {31'b0, busy_f}, 32'd0);
    check("midrst_ferr", {31'b0, err_f}, 32'd0);
    drive(1'b0, 1'b1, 32);
    push(1'b0, 1'b0, 8'h7E);
    send_frame(1'b0, 8'h7E, 16, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 16);
    wait_drain(1'b0, 200);

    // Baud tolerance at 1250 clk/bit: +2% then -2% bit period.
    drive(1'b1, 1'b1, 2500);
    push(1'b1, 1'b0, 8'h5A);
    send_frame(1'b1, 8'h5A, 1275, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 2500);
    wait_drain(1'b1, 3000);
    push(1'b1, 1'b0, 8'h5A);
    send_frame(1'b1, 8'h5A, 1225, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 2500);
    wait_drain(1'b1, 3000);
    check("slow_data_held", {24'b0, data_s}, 32'h5A);

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
